// File: rtl/axi_lite_ls_master.sv
// AXI4-Lite master for the core's external load/store requests: it stalls the pipeline
// while busy, then returns extended load data and the writeback register in a one-cycle DONE.
module axi_lite_ls_master #(
    parameter int AXI_ADDR_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      init_i,
    input  logic [31:0]               addr_i,
    input  logic [31:0]               data_w_i,
    input  logic                      we_i,
    input  logic [2:0]                funct3_i,
    input  logic [4:0]                rd_addr_i,
    output logic                      stall_o,
    output logic                      err_o,
    output logic [31:0]               rdata_o,
    output logic                      rd_we_o,
    output logic [4:0]                rd_addr_o,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [31:0]               m_axi_wdata,
    output logic [3:0]                m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [31:0]               m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    typedef enum logic [2:0] {
        S_IDLE, S_WADDR_DATA, S_WRESP, S_RADDR, S_RDATA, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, data_q, rdata_raw_q;
    logic [2:0]  funct3_q;
    logic [4:0]  rd_addr_q;
    logic        we_q, aw_done_q, w_done_q, err_q, misalign_q;
    logic        misalign_req, accept;
    logic [AXI_ADDR_WIDTH-1:0] axi_addr;
    logic [31:0] load_shifted, load_ext;
    logic        done;

    assign accept = (state_q == S_IDLE) && init_i;

    // Unsupported width codes take the same no-traffic error path as misaligned accesses.
    always_comb begin
        misalign_req = 1'b0;
        case (funct3_i[1:0])
            2'b01:   misalign_req = addr_i[0];
            2'b10:   misalign_req = (addr_i[1:0] != 2'b00) || (!we_i && funct3_i[2]);
            2'b11:   misalign_req = 1'b1;
            default: misalign_req = 1'b0;
        endcase
    end

    generate
        if (AXI_ADDR_WIDTH <= 32) begin : g_addr_trunc
            assign axi_addr = addr_q[AXI_ADDR_WIDTH-1:0];
        end else begin : g_addr_pad
            assign axi_addr = {{(AXI_ADDR_WIDTH-32){1'b0}}, addr_q};
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (init_i) begin
                    if (misalign_req) state_d = S_DONE;
                    else if (we_i)    state_d = S_WADDR_DATA;
                    else              state_d = S_RADDR;
                end
            end
            S_WADDR_DATA: begin
                if ((aw_done_q || (m_axi_awvalid && m_axi_awready)) &&
                    (w_done_q  || (m_axi_wvalid  && m_axi_wready)))
                    state_d = S_WRESP;
            end
            S_WRESP:  if (m_axi_bvalid)  state_d = S_DONE;
            S_RADDR:  if (m_axi_arready) state_d = S_RDATA;
            S_RDATA:  if (m_axi_rvalid)  state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q      <= '0;
            data_q      <= '0;
            we_q        <= 1'b0;
            funct3_q    <= '0;
            rd_addr_q   <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            err_q       <= 1'b0;
            misalign_q  <= 1'b0;
            rdata_raw_q <= '0;
        end else begin
            if (accept) begin
                addr_q     <= addr_i;
                data_q     <= data_w_i;
                we_q       <= we_i;
                funct3_q   <= funct3_i;
                rd_addr_q  <= rd_addr_i;
                aw_done_q  <= 1'b0;
                w_done_q   <= 1'b0;
                err_q      <= 1'b0;
                misalign_q <= misalign_req;
            end
            if (m_axi_awvalid && m_axi_awready) aw_done_q <= 1'b1;
            if (m_axi_wvalid && m_axi_wready)   w_done_q  <= 1'b1;
            if (m_axi_bready && m_axi_bvalid)   err_q     <= (m_axi_bresp != 2'b00);
            if (m_axi_rready && m_axi_rvalid) begin
                rdata_raw_q <= m_axi_rdata;
                err_q       <= (m_axi_rresp != 2'b00);
            end
        end
    end

    // Aligned halves have addr[0]=0, so a byte-granular shift selects byte and half lanes alike.
    assign load_shifted = rdata_raw_q >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_ext = '0;
        case (funct3_q)
            3'b000:  load_ext = {{24{load_shifted[7]}}, load_shifted[7:0]};
            3'b001:  load_ext = {{16{load_shifted[15]}}, load_shifted[15:0]};
            3'b010:  load_ext = rdata_raw_q;
            3'b100:  load_ext = {24'd0, load_shifted[7:0]};
            3'b101:  load_ext = {16'd0, load_shifted[15:0]};
            default: load_ext = '0;
        endcase
    end

    always_comb begin
        done          = (state_q == S_DONE);
        stall_o       = !rst_i && (accept || ((state_q != S_IDLE) && !done));
        m_axi_awvalid = (state_q == S_WADDR_DATA) && !aw_done_q;
        m_axi_wvalid  = (state_q == S_WADDR_DATA) && !w_done_q;
        m_axi_bready  = (state_q == S_WRESP);
        m_axi_arvalid = (state_q == S_RADDR);
        m_axi_rready  = (state_q == S_RDATA);
        m_axi_awaddr  = m_axi_awvalid ? axi_addr : '0;
        m_axi_araddr  = m_axi_arvalid ? axi_addr : '0;
        m_axi_wstrb   = 4'b0000;
        m_axi_wdata   = '0;
        if (m_axi_wvalid) begin
            case (funct3_q[1:0])
                2'b00: begin
                    m_axi_wstrb = 4'b0001 << addr_q[1:0];
                    m_axi_wdata = {4{data_q[7:0]}};
                end
                2'b01: begin
                    m_axi_wstrb = 4'b0011 << {addr_q[1], 1'b0};
                    m_axi_wdata = {2{data_q[15:0]}};
                end
                default: begin
                    m_axi_wstrb = 4'b1111;
                    m_axi_wdata = data_q;
                end
            endcase
        end
        rd_we_o   = done && !we_q && !misalign_q && !err_q;
        err_o     = done && (err_q || misalign_q);
        rdata_o   = rd_we_o ? load_ext : '0;
        rd_addr_o = rd_we_o ? rd_addr_q : '0;
    end

endmodule

// File: tb/tb_axi_lite_ls_master.sv
// Directed bench for axi_lite_ls_master: a latency/traffic model predicts every output per cycle,
// and a delay-programmable AXI slave responds to the DUT.
module tb_axi_lite_ls_master;

    logic        clk = 1'b0;
    logic        rst_i, init_i, we_i;
    logic [31:0] addr_i, data_w_i;
    logic [2:0]  funct3_i;
    logic [4:0]  rd_addr_i;
    logic        stall_o, err_o, rd_we_o;
    logic [31:0] rdata_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;
    logic [1:0]  m_axi_bresp, m_axi_rresp;

    axi_lite_ls_master #(.AXI_ADDR_WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst_i), .init_i(init_i), .addr_i(addr_i), .data_w_i(data_w_i),
        .we_i(we_i), .funct3_i(funct3_i), .rd_addr_i(rd_addr_i), .stall_o(stall_o),
        .err_o(err_o), .rdata_o(rdata_o), .rd_we_o(rd_we_o), .rd_addr_o(rd_addr_o),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Current transaction and the model's expectations for it
    bit          txn_active = 0;
    int          k = 0;
    logic        t_we, t_mis;
    logic [2:0]  t_f3;
    logic [31:0] t_addr, t_data, t_raw;
    logic [4:0]  t_rd;
    logic [1:0]  t_resp;
    int          awd, wd, bd, ard, rdd, exp_done;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata, exp_load;
    int          obs_done, obs_err_k;
    logic [3:0]  obs_wstrb;
    logic [31:0] obs_wdata, obs_rdata;
    logic [4:0]  obs_rd;

    function automatic bit model_misaligned(input logic we, input logic [2:0] f3,
                                            input logic [31:0] a);
        int size;
        if (f3[1:0] == 2'b11) return 1'b1;
        if (!we && (f3 == 3'b110)) return 1'b1;
        size = 1 << f3[1:0];
        return (a % size) != 0;
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
        int size = 1 << f3[1:0];
        return 4'(((1 << size) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        int size = 1 << f3[1:0];
        logic [31:0] r = 0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % size) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] raw);
        logic [31:0] v = raw >> (8 * (a % 4));
        case (f3)
            3'b000: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
            3'b001: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            3'b100: v = v % 256;
            3'b101: v = v % 65536;
            3'b010: v = raw;
            default: v = 0;
        endcase
        return v;
    endfunction

    // Slave: each READY/response VALID comes after the programmed number of waiting cycles
    int aw_seen = 0, w_seen = 0, b_seen = 0, ar_seen = 0, r_seen = 0;
    initial begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
        m_axi_arready = 0; m_axi_rvalid = 0;
        forever begin
            @(negedge clk);
            m_axi_awready = m_axi_awvalid && (aw_seen >= awd);
            m_axi_wready  = m_axi_wvalid  && (w_seen  >= wd);
            m_axi_bvalid  = m_axi_bready  && (b_seen  >= bd);
            m_axi_arready = m_axi_arvalid && (ar_seen >= ard);
            m_axi_rvalid  = m_axi_rready  && (r_seen  >= rdd);
            aw_seen = m_axi_awvalid ? aw_seen + 1 : 0;
            w_seen  = m_axi_wvalid  ? w_seen  + 1 : 0;
            b_seen  = m_axi_bready  ? b_seen  + 1 : 0;
            ar_seen = m_axi_arvalid ? ar_seen + 1 : 0;
            r_seen  = m_axi_rready  ? r_seen  + 1 : 0;
        end
    end
    assign m_axi_bresp = t_resp;
    assign m_axi_rresp = t_resp;
    assign m_axi_rdata = t_raw;

    // Per-cycle compare against the model; outside a transaction everything must be quiet
    initial forever begin
        @(negedge clk);
        if (txn_active) begin
            bit st, ld;
            int m;
            st = t_we && !t_mis;
            ld = !t_we && !t_mis;
            m  = (awd > wd) ? awd : wd;
            chk("stall_o", stall_o, k < exp_done);
            chk("awvalid", m_axi_awvalid, st && k >= 1 && k <= 1 + awd);
            chk("wvalid",  m_axi_wvalid,  st && k >= 1 && k <= 1 + wd);
            chk("bready",  m_axi_bready,  st && k >= 2 + m && k <= 2 + m + bd);
            chk("arvalid", m_axi_arvalid, ld && k >= 1 && k <= 1 + ard);
            chk("rready",  m_axi_rready,  ld && k >= 2 + ard && k <= 2 + ard + rdd);
            chk("rd_we_o", rd_we_o, (k == exp_done) && ld && (t_resp == 2'b00));
            chk("err_o",   err_o,   (k == exp_done) && (t_mis || (t_resp != 2'b00)));
            if (m_axi_awvalid) chk("awaddr", m_axi_awaddr, t_addr);
            if (m_axi_arvalid) chk("araddr", m_axi_araddr, t_addr);
            if (m_axi_wvalid) begin
                chk("wstrb", m_axi_wstrb, exp_wstrb);
                chk("wdata", m_axi_wdata, exp_wdata);
                obs_wstrb = m_axi_wstrb;
                obs_wdata = m_axi_wdata;
            end
            if (rd_we_o) begin
                chk("rdata_o",   rdata_o,   exp_load);
                chk("rd_addr_o", rd_addr_o, t_rd);
                obs_rdata = rdata_o;
                obs_rd    = rd_addr_o;
            end
            if (err_o) obs_err_k = k;
            if (k >= 1 && !stall_o && obs_done < 0) obs_done = k;
            k++;
        end else begin
            chk("idle_stall", stall_o, 0);
            chk("idle_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                                m_axi_rready}, 0);
            chk("idle_rd_we_err", {rd_we_o, err_o}, 0);
        end
    end

    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input logic [4:0] rd, input logic [31:0] raw,
                           input logic [1:0] resp, input int d_aw, input int d_w, input int d_b,
                           input int d_ar, input int d_r, input bit wait_done);
        @(posedge clk); #1;
        t_we = we; t_f3 = f3; t_addr = a; t_data = d; t_rd = rd; t_raw = raw; t_resp = resp;
        awd = d_aw; wd = d_w; bd = d_b; ard = d_ar; rdd = d_r;
        t_mis     = model_misaligned(we, f3, a);
        exp_wstrb = model_strb(f3, a);
        exp_wdata = model_wdata(f3, d);
        exp_load  = model_load(f3, a, raw);
        if (t_mis)   exp_done = 1;
        else if (we) exp_done = 3 + ((d_aw > d_w) ? d_aw : d_w) + d_b;
        else         exp_done = 3 + d_ar + d_r;
        obs_done = -1; obs_err_k = -1; obs_wstrb = 0; obs_wdata = 0; obs_rdata = 0; obs_rd = 0;
        we_i = we; funct3_i = f3; addr_i = a; data_w_i = d; rd_addr_i = rd;
        init_i = 1; k = 0; txn_active = 1;
        @(posedge clk); #1;
        init_i = 0;
        addr_i = 32'hFFFF_FFFF; data_w_i = 32'h0; funct3_i = 3'b111; rd_addr_i = 5'h1F;
        if (wait_done) begin
            while (k <= exp_done + 1) @(posedge clk);
            #1 txn_active = 0;
            $display("[TB] txn we=%0d f3=%0d addr=%h done_k=%0d err_k=%0d wstrb=%h wdata=%h rdata=%h rd=%0d",
                     we, f3, a, obs_done, obs_err_k, obs_wstrb, obs_wdata, obs_rdata, obs_rd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t actual=timeout required=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1; init_i = 1; we_i = 0; addr_i = 0; data_w_i = 0; funct3_i = 0; rd_addr_i = 0;
        t_resp = 0; t_raw = 0; awd = 0; wd = 0; bd = 0; ard = 0; rdd = 0;
        #12;
        chk("rst_stall_with_init", stall_o, 0);
        chk("rst_outputs", {err_o, rd_we_o, rdata_o, rd_addr_o}, 0);
        chk("rst_axi", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready,
                        m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_wstrb}, 0);
        init_i = 0;
        @(posedge clk); #1 rst_i = 0;

        // SW, ready held high: DONE on the fourth cycle counting the request cycle
        run_txn(1, 3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("sw_wstrb", obs_wstrb, 4'hF);
        chk("sw_wdata", obs_wdata, 32'hDEAD_BEEF);
        chk("sw_done_cycle", obs_done, 3);
        chk("sw_no_err", obs_err_k, 32'hFFFF_FFFF);

        run_txn(1, 3'b000, 32'h0000_2003, 32'h0000_00A5, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("sb_wstrb", obs_wstrb, 4'b1000);
        chk("sb_wdata", obs_wdata, 32'hA5A5_A5A5);
        run_txn(0, 3'b000, 32'h0000_2003, 0, 7, 32'hA500_0000, 0, 0, 0, 0, 0, 0, 1);
        chk("lb_rdata", obs_rdata, 32'hFFFF_FFA5);
        chk("lb_done_cycle", obs_done, 3);
        run_txn(0, 3'b100, 32'h0000_2003, 0, 7, 32'hA500_0000, 0, 0, 0, 0, 0, 0, 1);
        chk("lbu_rdata", obs_rdata, 32'h0000_00A5);
        chk("lbu_rd", obs_rd, 7);
        run_txn(1, 3'b001, 32'h0000_2002, 32'h0000_1234, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("sh_wstrb", obs_wstrb, 4'b1100);
        chk("sh_wdata", obs_wdata, 32'h1234_1234);
        run_txn(0, 3'b001, 32'h0000_2002, 0, 12, 32'h8001_0000, 0, 0, 0, 0, 0, 0, 1);
        chk("lh_rdata", obs_rdata, 32'hFFFF_8001);
        run_txn(0, 3'b101, 32'h0000_2002, 0, 13, 32'h8001_0000, 0, 0, 0, 0, 0, 0, 1);
        chk("lhu_rdata", obs_rdata, 32'h0000_8001);

        // Delayed AWREADY with immediate WREADY, then the mirror case with a BRESP error
        run_txn(1, 3'b010, 32'h0000_1004, 32'h0BAD_F00D, 0, 0, 0, 3, 0, 1, 0, 0, 1);
        chk("sw_awdelay_done", obs_done, 7);
        run_txn(1, 3'b000, 32'h0000_1001, 32'h0000_0042, 0, 0, 2'b10, 0, 2, 0, 0, 0, 1);
        chk("sb_bresp_err_cycle", obs_err_k, 5);

        // Misaligned LH: no traffic, error in the cycle after the request
        run_txn(0, 3'b001, 32'h0000_3001, 0, 9, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 1);
        chk("lh_mis_err_cycle", obs_err_k, 1);
        chk("lh_mis_done", obs_done, 1);

        run_txn(0, 3'b010, 32'h0000_3000, 0, 4, 32'h1111_2222, 2'b10, 0, 0, 0, 0, 0, 1);
        chk("lw_rresp_err_cycle", obs_err_k, 3);
        run_txn(0, 3'b010, 32'h0000_3004, 0, 5, 32'hCAFE_0001, 0, 0, 0, 0, 2, 1, 1);
        chk("lw_delay_done", obs_done, 6);
        chk("lw_delay_rdata", obs_rdata, 32'hCAFE_0001);

        // Reset while waiting in RDATA
        run_txn(0, 3'b010, 32'h0000_5000, 0, 6, 32'h5555_AAAA, 0, 0, 0, 0, 0, 5, 0);
        while (k < 4) @(posedge clk);
        #1 chk("pre_rst_rready", m_axi_rready, 1);
        #1 rst_i = 1; txn_active = 0;
        #1 chk("midrst_outputs", {stall_o, err_o, rd_we_o, rdata_o, rd_addr_o}, 0);
        chk("midrst_axi", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                           m_axi_rready}, 0);
        repeat (2) @(posedge clk);
        #1 rst_i = 0;
        run_txn(0, 3'b010, 32'h0000_4000, 0, 3, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 1);
        chk("post_rst_rdata", obs_rdata, 32'h1234_5678);
        chk("post_rst_rd", obs_rd, 3);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_lite_ls_master.md
Name:
axi_lite_ls_master

Overview:
Multi-cycle AXI4-Lite master that executes the external (non-DMEM) load/store requests produced by the DMEM/AXI address-decode mux in the RV32I core. It stalls the pipeline while busy, then returns sign/zero-extended load data and the destination register for writeback.

Parameters:
AXI_ADDR_WIDTH, 32, width of AWADDR/ARADDR (address bits above this are dropped)

Ports:
clk_i  in  1  core clock
rst_i  in  1  asynchronous active-high reset
init_i  in  1  start request (one-cycle or held; sampled only in IDLE)
addr_i  in  32  byte address
data_w_i  in  32  store data, unaligned in the low bits
we_i  in  1  1 = store, 0 = load
funct3_i  in  3  RV32I width/sign code
rd_addr_i  in  5  load destination register
stall_o  out  1  pipeline hold
err_o  out  1  one-cycle pulse on misalign or bus error
rdata_o  out  32  extended load result
rd_we_o  out  1  one-cycle register-file write enable
rd_addr_o  out  5  writeback register
m_axi_awaddr  out  AXI_ADDR_WIDTH  write address
m_axi_awvalid  out  1  write address valid
m_axi_awready  in  1  write address ready
m_axi_wdata  out  32  lane-replicated write data
m_axi_wstrb  out  4  byte strobes
m_axi_wvalid  out  1  write data valid
m_axi_wready  in  1  write data ready
m_axi_bresp  in  2  write response
m_axi_bvalid  in  1  write response valid
m_axi_bready  out  1  write response ready
m_axi_araddr  out  AXI_ADDR_WIDTH  read address
m_axi_arvalid  out  1  read address valid
m_axi_arready  in  1  read address ready
m_axi_rdata  in  32  read data
m_axi_rresp  in  2  read response
m_axi_rvalid  in  1  read data valid
m_axi_rready  out  1  read data ready

Behaviour:
- Reset (async): state IDLE; every output is 0, including all VALID/READY, rdata_o, rd_addr_o, stall_o and err_o. Reset mid-transaction drops VALIDs immediately and discards the request.
- States: IDLE, WADDR_DATA, WRESP, RADDR, RDATA, DONE. In IDLE, init_i=1 registers addr, data, we, funct3 and rd_addr. init_i is ignored in every other state.
- stall_o = (IDLE & init_i) | (state not IDLE and not DONE). This signal is combinational so the request cycle itself stalls.
- Store path: init goes to WADDR_DATA. AWVALID and WVALID both rise one cycle after init. Each VALID drops independently after its own handshake, and handshakes may occur in the same cycle. When both handshakes are done the state goes to WRESP with BREADY=1. On BVALID the state goes to DONE.
- Load path: init goes to RADDR with ARVALID=1. On ARREADY the state goes to RDATA with RREADY=1. On RVALID the state captures RDATA and RRESP and goes to DONE.
- Strobes and data by funct3[1:0]:
  - 00: wstrb = 0001<<addr[1:0], wdata = {4{byte}}.
  - 01: wstrb = 0011<<{addr[1],0}, wdata = {2{half}}.
  - 10: wstrb = 1111, wdata = word.
- AWADDR and ARADDR carry the full captured address.
- Load extension: the lane is selected by addr[1:0] (byte) or addr[1] (half).
  - funct3 000: LB, sign-extended byte.
  - funct3 001: LH, sign-extended half.
  - funct3 010: LW, full word.
  - funct3 100: LBU, zero-extended byte.
  - funct3 101: LHU, zero-extended half.
  - Any other funct3 is treated as misaligned.
- Misaligned request (half with addr[0]=1, or word with addr[1:0]≠0): no AXI traffic is issued; the state goes directly to DONE with err_o=1.
- DONE lasts exactly one cycle, with stall_o=0.
  - rd_we_o=1 only for a load whose RRESP=00 and which was not misaligned.
  - rdata_o and rd_addr_o are valid while rd_we_o=1.
  - err_o=1 if BRESP/RRESP≠00 or the request was misaligned.
  - Next state is IDLE.
- Minimum latency with READY tied high: store is 4 cycles init→DONE; load is 4 cycles.

Test Plan:
1. SW addr 0x0000_1000 data 0xDEADBEEF, awready/wready/bvalid held high → wstrb 1111, wdata DEADBEEF, DONE at cycle 4, rd_we_o=0, err_o=0.
2. SB addr 0x0000_2003 data 0x0000_00A5 → wstrb 1000, wdata A5A5A5A5. Then LB at the same address with rdata A5000000 → rdata_o FFFFFFA5. LBU at the same address → rdata_o 000000A5, rd_addr_o as issued.
3. Store with awready delayed 3 cycles and wready immediate → WVALID drops after 1 cycle, AWVALID is held until its handshake, a single BREADY phase follows, stall_o stays high throughout.
4. LH addr 0x0000_3001 → no AXI VALIDs, err_o=1, rd_we_o=0 one cycle after init.
5. LW with rresp=10 → err_o=1, rd_we_o=0. Assert rst_i during RDATA → all outputs 0 immediately, and the next init_i is accepted normally.
